pipe_adder: RTL and testbench
=============================

Name: pipe_adder

Overview:
- Parametrised, fully pipelined WIDTH-bit adder/subtractor. This is the clocked successor of the team's 32-bit combinational adder.
- Operands are split into CHUNK-bit slices. One slice is added per pipeline stage, and the carry is registered between stages.
- Accepts one operation per cycle with a valid qualifier. Used wherever a wide add must meet timing at the system clock.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CHUNK, 8: slice width per stage. WIDTH must be an integer multiple of CHUNK.
- STAGES (localparam), WIDTH/CHUNK: pipeline depth. This is not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  a, b, cin and sub are valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in; ignored when sub=1.
- sub  input  1  1 = compute a - b; 0 = compute a + b + cin.
- out_valid  output  1  sum and cout hold a completed result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB. In sub mode, 1 = no borrow (a >= b unsigned).

Behaviour:
- Arithmetic: result = a + (sub ? ~b : b) + (sub ? 1 : cin), computed at WIDTH+1 bits.
  - sum = result[WIDTH-1:0].
  - cout = result[WIDTH].
- Pipeline structure:
  - Stage k (k = 0..STAGES-1) adds slice k of a and of b' (b' = b or ~b, per sub) plus the registered carry from stage k-1.
  - Stage 0 uses cin, or 1 when sub=1.
  - Slices above k are carried forward unchanged in skew registers.
  - Completed lower slices are carried forward in de-skew registers, so all slices of one operation emerge together.
- Latency: an operation sampled with in_valid=1 at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. during cycle N+STAGES-1 to N+STAGES.
  - Exactly STAGES register stages; no combinational path from inputs to outputs.
  - With STAGES=1 (CHUNK=WIDTH) the block is a single registered adder.
- Throughput: one operation per cycle, no backpressure, no stalls.
  - in_valid may toggle arbitrarily.
  - A cycle with in_valid=0 propagates as a bubble: out_valid=0 exactly STAGES cycles later.
- Output hold when not valid: the data path of a bubble is don't-care internally. sum and cout retain their last valid values and are not updated on bubbles.
- Reset, synchronous: on a clock edge with reset=1:
  - all valid bits in every stage clear to 0;
  - sum = 0, cout = 0, out_valid = 0.
- Reset mid-stream: every in-flight operation is discarded. No out_valid pulse occurs for operations accepted before the reset edge.
  - An operation presented on the same edge as reset=1 is also discarded.
  - The first post-reset operation is the one sampled on the first edge with reset=0.
- Boundary cases:
  - Carry must propagate across every slice boundary, e.g. 0x0000FFFF + 1 = 0x00010000.
  - Full wrap: 0xFFFFFFFF + 1 gives sum=0, cout=1.
  - sub with a=b gives sum=0, cout=1.
- Parameter check: if WIDTH % CHUNK != 0 or CHUNK < 1, elaboration fails via a generate-time error. No silent truncation.

Optional Feature:
- Macro: PIPE_ADDER_OVF_EN
- Defined:
  - Adds output port ovf (1 bit), aligned with sum and cout.
  - ovf = signed two's-complement overflow: operand sign bits (a, b') equal and sum sign differs.
  - Resets to 0; holds its last value on bubbles like sum.
- Undefined:
  - The port and its logic are absent.
  - Behaviour is otherwise identical.

Test Plan (WIDTH=32, CHUNK=8, STAGES=4 unless noted):
- Reset, then a=0, b=1, cin=0, sub=0 for one cycle -> out_valid high exactly 4 edges later, sum=0x00000001, cout=0. out_valid low in all other cycles.
- Back-to-back stream on consecutive cycles: (0,2), (1,2), (0xFFFF,0), (0xFFFF,1), (0xFFFF,0x2CCC1) -> five consecutive valid outputs 0x2, 0x3, 0xFFFF, 0x10000, 0x3CCC0, in order.
- Wrap and carry: a=0xFFFFFFFF, b=1 -> sum=0, cout=1. Then a=0x7FFFFFFF, b=1 -> sum=0x80000000, cout=0 (ovf=1 when PIPE_ADDER_OVF_EN is defined).
- Subtract: sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0. Then sub=1, a=7, b=5 -> sum=2, cout=1. Then cin=1 with sub=1 is ignored (result unchanged).
- Bubbles and reset mid-stream:
  - Stimulus: valid pattern 1,0,1 with reset asserted one cycle after the third op is accepted.
  - Response: only the first op emerges (out_valid pulse, then bubble); no pulse for the third op; sum=0, cout=0 after the reset edge.
- Parameter sweep: CHUNK=32 (STAGES=1) and WIDTH=16, CHUNK=4 -> latency equals STAGES. 0xFFFF+1 on 16 bits gives sum=0, cout=1.

Source files
------------

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit adder/subtractor that adds one CHUNK-bit slice per pipeline stage.
// Defining PIPE_ADDER_OVF_EN adds the signed-overflow output ovf.
module pipe_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int STAGES     = WIDTH / CHUNK_SAFE;
  localparam int LAST       = STAGES - 1;

  if ((CHUNK < 1) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_param_check
    $error("pipe_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  function automatic logic [WIDTH-1:0] put_slice(
    input logic [WIDTH-1:0]      word,
    input logic [CHUNK_SAFE-1:0] slice,
    input int                    idx
  );
    logic [WIDTH-1:0] result;
    result = word;
    result[idx*CHUNK_SAFE +: CHUNK_SAFE] = slice;
    return result;
  endfunction

  // What each stage sees on its inputs, and what it produces
  logic [WIDTH-1:0]  a_stg_s   [STAGES];
  logic [WIDTH-1:0]  b_stg_s   [STAGES];
  logic [WIDTH-1:0]  s_stg_s   [STAGES];
  logic              c_stg_s   [STAGES];
  logic              v_stg_s   [STAGES];
  logic [CHUNK_SAFE:0] slice_s [STAGES];
  logic [WIDTH-1:0]  s_nxt_s   [STAGES];
  logic              c_nxt_s   [STAGES];

  // Stage registers; entry LAST doubles as the output register
  logic [WIDTH-1:0]  a_r [STAGES];
  logic [WIDTH-1:0]  b_r [STAGES];
  logic [WIDTH-1:0]  s_r [STAGES];
  logic              c_r [STAGES];
  logic              v_r [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Subtraction is a + ~b + 1, so the inversion and forced carry happen up front
      assign a_stg_s[k] = a;
      assign b_stg_s[k] = sub ? ~b : b;
      assign c_stg_s[k] = sub ? 1'b1 : cin;
      assign s_stg_s[k] = {WIDTH{1'b0}};
      assign v_stg_s[k] = in_valid;
    end else begin : g_tail
      assign a_stg_s[k] = a_r[k-1];
      assign b_stg_s[k] = b_r[k-1];
      assign c_stg_s[k] = c_r[k-1];
      assign s_stg_s[k] = s_r[k-1];
      assign v_stg_s[k] = v_r[k-1];
    end

    assign slice_s[k] = {1'b0, a_stg_s[k][k*CHUNK_SAFE +: CHUNK_SAFE]}
                      + {1'b0, b_stg_s[k][k*CHUNK_SAFE +: CHUNK_SAFE]}
                      + {{CHUNK_SAFE{1'b0}}, c_stg_s[k]};
    assign s_nxt_s[k] = put_slice(s_stg_s[k], slice_s[k][CHUNK_SAFE-1:0], k);
    assign c_nxt_s[k] = slice_s[k][CHUNK_SAFE];
  end

  // Advance the pipeline; data only moves with a valid token so the outputs hold across bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k] <= 1'b0;
        s_r[k] <= {WIDTH{1'b0}};
        c_r[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k] <= v_stg_s[k];
        if (v_stg_s[k]) begin
          a_r[k] <= a_stg_s[k];
          b_r[k] <= b_stg_s[k];
          s_r[k] <= s_nxt_s[k];
          c_r[k] <= c_nxt_s[k];
        end
      end
    end
  end

  assign out_valid = v_r[LAST];
  assign sum       = s_r[LAST];
  assign cout      = c_r[LAST];

`ifdef PIPE_ADDER_OVF_EN
  logic ovf_r;

  // Signed overflow: operands share a sign bit that the result does not
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (v_stg_s[LAST]) begin
      ovf_r <= (a_stg_s[LAST][WIDTH-1] == b_stg_s[LAST][WIDTH-1])
            && (s_nxt_s[LAST][WIDTH-1] != a_stg_s[LAST][WIDTH-1]);
    end
  end

  assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: three configurations (32/8, 32/32, 16/4) share one stimulus
// stream; expected results come from a plain-arithmetic model and are checked by a monitor.
`timescale 1ns/1ps
module tb_pipe_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] a_drv = 32'h0;
  logic [31:0] b_drv = 32'h0;

  logic        ov_s [3];
  logic [31:0] sm_s [3];
  logic        co_s [3];
  logic [15:0] sm16;
`ifdef PIPE_ADDER_OVF_EN
  logic        of_s [3];
  logic        last_ovf [3];
`endif

  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t sb_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_adder #(.WIDTH(32), .CHUNK(8)) u_w32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a_drv), .b(b_drv), .cin(cin), .sub(sub),
    .out_valid(ov_s[0]), .sum(sm_s[0]), .cout(co_s[0])
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(of_s[0])
`endif
  );

  pipe_adder #(.WIDTH(32), .CHUNK(32)) u_one (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a_drv), .b(b_drv), .cin(cin), .sub(sub),
    .out_valid(ov_s[1]), .sum(sm_s[1]), .cout(co_s[1])
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(of_s[1])
`endif
  );

  pipe_adder #(.WIDTH(16), .CHUNK(4)) u_w16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a_drv[15:0]), .b(b_drv[15:0]), .cin(cin),
    .sub(sub), .out_valid(ov_s[2]), .sum(sm16), .cout(co_s[2])
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(of_s[2])
`endif
  );

  assign sm_s[2] = {16'h0000, sm16};

  function automatic int width_of(input int i);
    case (i)
      0: return 32;
      1: return 32;
      default: return 16;
    endcase
  endfunction

  function automatic int stages_of(input int i);
    case (i)
      0: return 4;
      1: return 1;
      default: return 4;
    endcase
  endfunction

  // Reference: unsigned arithmetic for sum/cout, true signed range test for ovf
  function automatic exp_t model(input int w, input logic [31:0] a_in, input logic [31:0] b_in,
                                 input bit c, input bit s, input int due);
    exp_t e;
    longint unsigned m, av, bv, t, half;
    longint sa, sbv, r, hi;
    m  = (64'd1 << w) - 64'd1;
    av = {32'h0, a_in} & m;
    bv = {32'h0, b_in} & m;
    if (s) begin
      t = (av - bv) & m;
      e.cout = (av >= bv);
    end else begin
      t = av + bv + {63'h0, c};
      e.cout = ((t >> w) & 64'd1) != 64'd0;
      t = t & m;
    end
    e.sum = t[31:0];
    half = 64'd1 << (w - 1);
    hi   = longint'(half);
    sa   = (av >= half) ? longint'(av) - 2 * hi : longint'(av);
    sbv  = (bv >= half) ? longint'(bv) - 2 * hi : longint'(bv);
    r    = s ? (sa - sbv) : (sa + sbv + longint'(c));
    e.ovf = (r >= hi) || (r < -hi);
    e.due = due;
    return e;
  endfunction

  task automatic check(input string what, input int i, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s inst%0d cycle %0d: got 0x%08h, expected 0x%08h", what, i, cyc, act, exp);
    end
  endtask

  // Drive one cycle of stimulus just after a rising edge; record expectations for accepted ops
  task automatic issue(input bit v, input logic [31:0] aa, input logic [31:0] bb,
                       input bit c, input bit s, input bit r);
    @(posedge clk);
    #2;
    in_valid = v;
    a_drv    = aa;
    b_drv    = bb;
    cin      = c;
    sub      = s;
    reset    = r;
    if (v && !r) begin
      for (int i = 0; i < 3; i++) begin
        sb_q[i].push_back(model(width_of(i), aa, bb, c, s, cyc + stages_of(i)));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) issue(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor
  exp_t        mon_e;
  logic [31:0] last_sum [3];
  logic        last_cout [3];
  bit          armed = 1'b0;
  bit          chk_rst = 1'b0;

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        if (chk_rst) begin
          check("reset_out_valid", i, {31'b0, ov_s[i]}, 32'h0);
          check("reset_sum", i, sm_s[i], 32'h0);
          check("reset_cout", i, {31'b0, co_s[i]}, 32'h0);
`ifdef PIPE_ADDER_OVF_EN
          check("reset_ovf", i, {31'b0, of_s[i]}, 32'h0);
`endif
        end
        if (ov_s[i] !== 1'b0) begin
          if (sb_q[i].size() == 0) begin
            check("spurious_valid", i, {31'b0, ov_s[i]}, 32'h0);
          end else begin
            mon_e = sb_q[i].pop_front();
            check("sum", i, sm_s[i], mon_e.sum);
            check("cout", i, {31'b0, co_s[i]}, {31'b0, mon_e.cout});
`ifdef PIPE_ADDER_OVF_EN
            check("ovf", i, {31'b0, of_s[i]}, {31'b0, mon_e.ovf});
            last_ovf[i] = mon_e.ovf;
`endif
            check("latency_cycle", i, cyc, mon_e.due);
            last_sum[i]  = mon_e.sum;
            last_cout[i] = mon_e.cout;
          end
        end else begin
          if (sb_q[i].size() != 0 && sb_q[i][0].due <= cyc) begin
            check("missing_valid", i, {31'b0, ov_s[i]}, 32'h1);
            void'(sb_q[i].pop_front());
          end
          check("hold_sum", i, sm_s[i], last_sum[i]);
          check("hold_cout", i, {31'b0, co_s[i]}, {31'b0, last_cout[i]});
`ifdef PIPE_ADDER_OVF_EN
          check("hold_ovf", i, {31'b0, of_s[i]}, {31'b0, last_ovf[i]});
`endif
        end
      end
    end
    chk_rst = 1'b0;
    if (reset === 1'b1) begin
      for (int i = 0; i < 3; i++) begin
        sb_q[i].delete();
        last_sum[i]  = 32'h0;
        last_cout[i] = 1'b0;
`ifdef PIPE_ADDER_OVF_EN
        last_ovf[i]  = 1'b0;
`endif
      end
      chk_rst = 1'b1;
      armed   = 1'b1;
    end
  end

  initial begin
    logic [31:0] ra, rb;
    issue(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Single op, then quiet
    issue(1'b1, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Back-to-back stream with carries crossing slice boundaries
    issue(1'b1, 32'h0,     32'h2,     1'b0, 1'b0, 1'b0);
    issue(1'b1, 32'h1,     32'h2,     1'b0, 1'b0, 1'b0);
    issue(1'b1, 32'hFFFF,  32'h0,     1'b0, 1'b0, 1'b0);
    issue(1'b1, 32'hFFFF,  32'h1,     1'b0, 1'b0, 1'b0);
    issue(1'b1, 32'hFFFF,  32'h2CCC1, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Wrap, signed overflow, carry-in
    issue(1'b1, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0);

    // Subtract, including cin ignored and a == b
    issue(1'b1, 32'h5, 32'h7, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 32'h7, 32'h5, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 32'h7, 32'h5, 1'b1, 1'b1, 1'b0);
    issue(1'b1, 32'h12345678, 32'h12345678, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 32'h80000000, 32'h1, 1'b0, 1'b1, 1'b0);
    idle(6);

    // Ops 1,_,3 then reset: op 1 emerges, op 3 is discarded
    issue(1'b1, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 1'b0);
    issue(1'b1, 32'h33, 32'h44, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 1'b0);
    issue(1'b1, 32'h55, 32'h66, 1'b0, 1'b0, 1'b1);
    issue(1'b1, 32'hABCD, 32'h1234, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Random traffic with toggling valid and occasional reset
    for (int n = 0; n < 400; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom();
      rb = ($urandom_range(0, 7) == 0) ? 32'h00000001 : $urandom();
      if ($urandom_range(0, 9) == 0) rb = ra;
      issue($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
    end
    idle(8);

    for (int i = 0; i < 3; i++) check("drain_empty", i, sb_q[i].size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
